// File: rtl/bm_mul_arbiter.sv
// Round-robin front end that shares one block-minifloat multiplier between NREQ requesters.
// Each requester has at most one operation in flight and a one-entry response buffer.
module bm_mul_arbiter #(
    parameter int e       = 3,
    parameter int m       = 4,
    parameter int NREQ    = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*(1+e+m)-1:0]       req_bm1,
    input  logic [NREQ*(1+e+m)-1:0]       req_bm2,
    output logic                          mul_valid,
    output logic [e+m:0]                  mul_bm1,
    output logic [e+m:0]                  mul_bm2,
    input  logic [2*m+e+3:0]              mul_result,
    input  logic                          mul_exp_ovf,
    output logic [NREQ-1:0]               rsp_valid,
    input  logic [NREQ-1:0]               rsp_ready,
    output logic [NREQ*(2*m+e+4)-1:0]     rsp_result,
    output logic [NREQ-1:0]               rsp_exp_ovf,
    output logic                          busy
);
    localparam int BM_W  = 1 + e + m;
    localparam int RES_W = 2*m + e + 4;
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]                 out_q, out_d;
    logic [ID_W-1:0]                 ptr_q, ptr_d;
    logic                            mul_valid_q, mul_valid_d;
    logic [BM_W-1:0]                 mul_bm1_q, mul_bm1_d;
    logic [BM_W-1:0]                 mul_bm2_q, mul_bm2_d;
    logic [ID_W-1:0]                 issue_id_q, issue_id_d;
    logic [MUL_LAT-1:0]              tag_vld_q, tag_vld_d;
    logic [MUL_LAT-1:0][ID_W-1:0]    tag_id_q, tag_id_d;
    logic [NREQ-1:0]                 rsp_valid_q, rsp_valid_d;
    logic [NREQ*RES_W-1:0]           rsp_result_q, rsp_result_d;
    logic [NREQ-1:0]                 rsp_ovf_q, rsp_ovf_d;
    logic                            busy_q, busy_d;

    logic [NREQ-1:0]                 elig_s;
    logic [NREQ-1:0]                 grant_s;
    logic                            gnt_any_s;
    logic [ID_W-1:0]                 gnt_id_s;
    logic                            hit_s;
    logic                            cap_s;
    logic [ID_W-1:0]                 cap_id_s;
    logic                            cap_hit_s;

    // Round-robin pick: first eligible index starting at ptr_q, wrapping modulo NREQ.
    always_comb begin
        elig_s    = req_valid & ~out_q;
        gnt_any_s = 1'b0;
        gnt_id_s  = '0;
        hit_s     = 1'b0;
        grant_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int c = 0; c < NREQ; c++) begin
                hit_s     = !gnt_any_s && elig_s[c] && (((int'(ptr_q) + k) % NREQ) == c);
                gnt_id_s  = hit_s ? ID_W'(c) : gnt_id_s;
                gnt_any_s = gnt_any_s | hit_s;
            end
        end
        for (int c = 0; c < NREQ; c++) begin
            grant_s[c] = gnt_any_s && (gnt_id_s == ID_W'(c));
        end
    end

    assign req_ready = grant_s;

    // Issue stage, pointer advance, outstanding flags and tag shift register.
    always_comb begin
        mul_valid_d = gnt_any_s;
        issue_id_d  = gnt_any_s ? gnt_id_s : '0;
        mul_bm1_d   = '0;
        mul_bm2_d   = '0;
        for (int c = 0; c < NREQ; c++) begin
            mul_bm1_d = grant_s[c] ? req_bm1[c*BM_W +: BM_W] : mul_bm1_d;
            mul_bm2_d = grant_s[c] ? req_bm2[c*BM_W +: BM_W] : mul_bm2_d;
        end
        ptr_d = gnt_any_s ? ((gnt_id_s == ID_W'(NREQ-1)) ? '0 : gnt_id_s + ID_W'(1)) : ptr_q;
        out_d = (out_q | grant_s) & ~(rsp_valid_q & rsp_ready);
        // The tag travels one cycle behind the grant so it lines up with mul_result.
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = mul_valid_q;
        tag_id_d[0]  = issue_id_q;
        for (int k = 1; k < MUL_LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
        busy_d = |out_d;
    end

    // Response buffers: capture when the tag emerges, release on handshake.
    always_comb begin
        cap_s        = tag_vld_q[MUL_LAT-1];
        cap_id_s     = tag_id_q[MUL_LAT-1];
        cap_hit_s    = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_ovf_d    = rsp_ovf_q;
        for (int c = 0; c < NREQ; c++) begin
            cap_hit_s                      = cap_s && (cap_id_s == ID_W'(c));
            rsp_valid_d[c]                 = cap_hit_s | (rsp_valid_q[c] & ~rsp_ready[c]);
            rsp_result_d[c*RES_W +: RES_W] = cap_hit_s ? mul_result : rsp_result_q[c*RES_W +: RES_W];
            rsp_ovf_d[c]                   = cap_hit_s ? mul_exp_ovf : rsp_ovf_q[c];
        end
    end

    // State registers; reset discards in-flight tags so late results are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            ptr_q        <= '0;
            mul_valid_q  <= 1'b0;
            mul_bm1_q    <= '0;
            mul_bm2_q    <= '0;
            issue_id_q   <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            out_q        <= out_d;
            ptr_q        <= ptr_d;
            mul_valid_q  <= mul_valid_d;
            mul_bm1_q    <= mul_bm1_d;
            mul_bm2_q    <= mul_bm2_d;
            issue_id_q   <= issue_id_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_ovf_q    <= rsp_ovf_d;
            busy_q       <= busy_d;
        end
    end

    assign mul_valid   = mul_valid_q;
    assign mul_bm1     = mul_bm1_q;
    assign mul_bm2     = mul_bm2_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_exp_ovf = rsp_ovf_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_bm_mul_arbiter.sv
// Directed bench for bm_mul_arbiter with a stand-in two-cycle multiplier.
// The stand-in returns {bm1[6:0], bm2} as the product and bm1[7] as the overflow flag.
module tb_bm_mul_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [15:0] req_bm1 = 16'h0000;
    logic [15:0] req_bm2 = 16'h0000;
    logic        mul_valid;
    logic [7:0]  mul_bm1;
    logic [7:0]  mul_bm2;
    logic [14:0] mul_result = 15'h0000;
    logic        mul_exp_ovf = 1'b0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [29:0] rsp_result;
    logic [1:0]  rsp_exp_ovf;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic        auto_en = 1'b0;
    logic [14:0] man_res = 15'h0000;
    logic        man_ovf = 1'b0;
    logic [14:0] p0_res = 15'h0000;
    logic [14:0] p1_res = 15'h0000;
    logic        p0_ovf = 1'b0;
    logic        p1_ovf = 1'b0;
    logic [1:0]  bp_rdy [0:16];
    logic [1:0]  bp_rv  [0:16];

    bm_mul_arbiter #(.e(3), .m(4), .NREQ(2), .MUL_LAT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_bm1     (req_bm1),
        .req_bm2     (req_bm2),
        .mul_valid   (mul_valid),
        .mul_bm1     (mul_bm1),
        .mul_bm2     (mul_bm2),
        .mul_result  (mul_result),
        .mul_exp_ovf (mul_exp_ovf),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_exp_ovf (rsp_exp_ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: result appears during the second cycle after mul_valid.
    always @(negedge clk) begin
        mul_result  = auto_en ? p1_res : man_res;
        mul_exp_ovf = auto_en ? p1_ovf : man_ovf;
        p1_res      = p0_res;
        p1_ovf      = p0_ovf;
        p0_res      = mul_valid ? {mul_bm1[6:0], mul_bm2} : 15'h0000;
        p0_ovf      = mul_valid ? mul_bm1[7] : 1'b0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        next_cycle();
        next_cycle();
        #1;
        check_eq("rst_mul_valid", {31'd0, mul_valid}, 32'd0);
        check_eq("rst_mul_bm1", {24'd0, mul_bm1}, 32'd0);
        check_eq("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_result", {2'd0, rsp_result}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        bp_rdy = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
                   2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
        bp_rv  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01,
                   2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};

        // Single operation with a hand-driven product.
        do_reset();
        next_cycle(); req_valid = 2'b01; req_bm1 = {8'h00, 8'h3C}; req_bm2 = {8'h00, 8'h75}; #1;
        check_eq("single_grant", {30'd0, req_ready}, 32'd1);
        next_cycle(); req_valid = 2'b00; #1;
        check_eq("single_mul_valid", {31'd0, mul_valid}, 32'd1);
        check_eq("single_bm1", {24'd0, mul_bm1}, 32'h3C);
        check_eq("single_bm2", {24'd0, mul_bm2}, 32'h75);
        check_eq("single_busy", {31'd0, busy}, 32'd1);
        next_cycle(); #1;
        check_eq("single_idle_mv", {31'd0, mul_valid}, 32'd0);
        check_eq("single_idle_bm1", {24'd0, mul_bm1}, 32'd0);
        next_cycle(); man_res = 15'h05A5; man_ovf = 1'b0; #1;
        check_eq("single_no_rsp_yet", {30'd0, rsp_valid}, 32'd0);
        next_cycle(); man_res = 15'h0000; #1;
        check_eq("single_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        check_eq("single_rsp_result", {17'd0, rsp_result[14:0]}, 32'h5A5);
        next_cycle(); rsp_ready = 2'b01; #1;
        check_eq("single_rsp_hold", {30'd0, rsp_valid}, 32'd1);
        next_cycle(); rsp_ready = 2'b00; #1;
        check_eq("single_rsp_drop", {30'd0, rsp_valid}, 32'd0);
        check_eq("single_busy_clr", {31'd0, busy}, 32'd0);
        check_eq("single_result_kept", {17'd0, rsp_result[14:0]}, 32'h5A5);

        // Fairness: pointer now favours requester 1, then strict alternation.
        auto_en   = 1'b1;
        rsp_ready = 2'b11;
        req_bm1   = {8'h15, 8'h21};
        req_bm2   = {8'h7E, 8'h43};
        for (int i = 0; i < 15; i++) begin
            next_cycle(); req_valid = 2'b11; #1;
            check_eq("fair_grant", {30'd0, req_ready},
                     (i % 5 == 0) ? 32'd2 : ((i % 5 == 1) ? 32'd1 : 32'd0));
        end
        req_valid = 2'b00;
        for (int i = 0; i < 8; i++) next_cycle();
        #1;
        check_eq("fair_drained", {31'd0, busy}, 32'd0);

        // Simultaneous requests from reset.
        do_reset();
        rsp_ready = 2'b11;
        next_cycle(); req_valid = 2'b11; #1;
        check_eq("sim_grant0", {30'd0, req_ready}, 32'd1);
        next_cycle(); req_valid = 2'b10; #1;
        check_eq("sim_grant1", {30'd0, req_ready}, 32'd2);
        check_eq("sim_mv0", {31'd0, mul_valid}, 32'd1);
        check_eq("sim_bm1_0", {24'd0, mul_bm1}, 32'h21);
        check_eq("sim_bm2_0", {24'd0, mul_bm2}, 32'h43);
        next_cycle(); req_valid = 2'b00; #1;
        check_eq("sim_mv1", {31'd0, mul_valid}, 32'd1);
        check_eq("sim_bm1_1", {24'd0, mul_bm1}, 32'h15);
        check_eq("sim_bm2_1", {24'd0, mul_bm2}, 32'h7E);
        next_cycle(); #1;
        check_eq("sim_rv_none", {30'd0, rsp_valid}, 32'd0);
        next_cycle(); #1;
        check_eq("sim_rv0", {30'd0, rsp_valid}, 32'd1);
        check_eq("sim_res0", {17'd0, rsp_result[14:0]}, 32'h2143);
        next_cycle(); #1;
        check_eq("sim_rv1", {30'd0, rsp_valid}, 32'd2);
        check_eq("sim_res1", {17'd0, rsp_result[29:15]}, 32'h157E);
        check_eq("sim_ovf", {30'd0, rsp_exp_ovf}, 32'd0);
        next_cycle(); #1;
        check_eq("sim_rv_done", {30'd0, rsp_valid}, 32'd0);
        check_eq("sim_busy", {31'd0, busy}, 32'd0);

        // Backpressure on requester 0; requester 1 keeps completing with overflow set.
        do_reset();
        req_bm1 = {8'h8A, 8'h3C};
        req_bm2 = {8'h0B, 8'h75};
        for (int i = 0; i < 17; i++) begin
            next_cycle(); req_valid = 2'b11; rsp_ready = (i >= 14) ? 2'b11 : 2'b10; #1;
            check_eq("bp_grant", {30'd0, req_ready}, {30'd0, bp_rdy[i]});
            check_eq("bp_rsp_valid", {30'd0, rsp_valid}, {30'd0, bp_rv[i]});
            check_eq("bp_ovf0", {31'd0, rsp_exp_ovf[0]}, 32'd0);
            if (bp_rv[i][0]) check_eq("bp_res0", {17'd0, rsp_result[14:0]}, 32'h3C75);
            if (bp_rv[i][1]) begin
                check_eq("bp_res1", {17'd0, rsp_result[29:15]}, 32'h0A0B);
                check_eq("bp_ovf1", {31'd0, rsp_exp_ovf[1]}, 32'd1);
            end
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int i = 0; i < 8; i++) next_cycle();

        // Reset one cycle after issue; the late product must be ignored.
        next_cycle(); req_valid = 2'b01; #1;
        check_eq("mid_grant", {30'd0, req_ready}, 32'd1);
        next_cycle(); req_valid = 2'b00; #1;
        check_eq("mid_mv", {31'd0, mul_valid}, 32'd1);
        next_cycle(); rst_n = 1'b0; #1;
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_result", {2'd0, rsp_result}, 32'd0);
        check_eq("mid_rst_ovf", {30'd0, rsp_exp_ovf}, 32'd0);
        check_eq("mid_rst_rv", {30'd0, rsp_valid}, 32'd0);
        next_cycle(); rst_n = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("mid_no_rsp", {30'd0, rsp_valid}, 32'd0);
            check_eq("mid_no_busy", {31'd0, busy}, 32'd0);
            next_cycle(); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
